cpu_mcu_port_controller: RTL and testbench



---
 rtl/cpu_mcu_port_controller_if.sv | 48 ++++
 rtl/cpu_mcu_port_controller.sv | 192 +++++++++++++++++++
 tb/tb_cpu_mcu_port_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_mcu_port_controller_if.sv
// ----------------------------------------------------------------------------
// cpu_mcu_port_controller_if
//
// Purpose: bundles the game-CPU side signals of the MB8841 port controller so
// the controller and its environment connect through one named port.
//
// Signals:
//   IN3_AL        CPU read strobe for the port, active-low, asynchronous
//   CLR_AL        sequence clear, active-low, synchronous to CPU_CLOCK
//   NMI_AL        NMI to the game CPU, active-low
//   MCU_DATA_OUT  4-bit value presented on DB3..DB0
//   MCU_DATA_OE   enable for the top-level DB3..DB0 tri-state drivers
//   STARTED       sticky, first CPU read seen since reset
//   FAULT         sticky, NMI retries exhausted without a read
//
// Modports:
//   master  the CPU/board side: drives the strobes, observes the outputs
//   slave   the controller: samples the strobes, drives the outputs
// ----------------------------------------------------------------------------
interface cpu_mcu_port_controller_if;
    logic       IN3_AL;
    logic       CLR_AL;
    logic       NMI_AL;
    logic [3:0] MCU_DATA_OUT;
    logic       MCU_DATA_OE;
    logic       STARTED;
    logic       FAULT;

    modport master (
        output IN3_AL,
        output CLR_AL,
        input  NMI_AL,
        input  MCU_DATA_OUT,
        input  MCU_DATA_OE,
        input  STARTED,
        input  FAULT
    );

    modport slave (
        input  IN3_AL,
        input  CLR_AL,
        output NMI_AL,
        output MCU_DATA_OUT,
        output MCU_DATA_OE,
        output STARTED,
        output FAULT
    );
endinterface

// File: rtl/cpu_mcu_port_controller.sv
// ----------------------------------------------------------------------------
// cpu_mcu_port_controller
//
// Purpose: controls the game CPU's port to the custom microcomputer (MB8841).
// After reset it issues a startup NMI to the game CPU and waits for the CPU to
// read the port. If no read arrives within the watchdog window, the NMI is
// re-pulsed a bounded number of times before FAULT is raised. Independently,
// each CPU read strobe (IN3_AL) returns the next value of a free-running
// 4-bit sequence and enables the top-level data bus drivers.
//
// Parameters:
//   NMI_DELAY    cycles from reset release to the first NMI pulse (>=1)
//   NMI_WIDTH    cycles NMI_AL is held low per pulse (>=1)
//   WDOG_CYCLES  cycles after a pulse in which a CPU read must occur (>=1)
//   MAX_RETRY    extra NMI pulses allowed before FAULT (0..15)
//
// Ports:
//   CPU_CLOCK  sole clock, everything changes on its rising edge
//   RESET      synchronous, active-high reset
//   port_if    slave side of cpu_mcu_port_controller_if (strobes in,
//              NMI/data/enable/status out, all outputs registered)
// ----------------------------------------------------------------------------
module cpu_mcu_port_controller #(
    parameter int NMI_DELAY   = 16,
    parameter int NMI_WIDTH   = 4,
    parameter int WDOG_CYCLES = 1024,
    parameter int MAX_RETRY   = 3
) (
    input  logic                      CPU_CLOCK,
    input  logic                      RESET,
    cpu_mcu_port_controller_if.slave  port_if
);

    // One shared counter serves every timed state, so it must hold the
    // largest terminal count among the three phases.
    localparam int CNT_MAX_A = (NMI_DELAY > NMI_WIDTH) ? NMI_DELAY : NMI_WIDTH;
    localparam int CNT_MAX   = (CNT_MAX_A > WDOG_CYCLES) ? CNT_MAX_A : WDOG_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    // DELAY ends on count NMI_DELAY because the counter starts at 0 on the
    // first edge after reset release; NMI_AL is registered off the next
    // state, which puts the first low cycle right at edge NMI_DELAY.
    localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(NMI_DELAY);
    localparam logic [CNT_W-1:0] WIDTH_END = CNT_W'(NMI_WIDTH - 1);
    localparam logic [CNT_W-1:0] WDOG_END  = CNT_W'(WDOG_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_DELAY,
        ST_PULSE,
        ST_WAIT,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [3:0]         retry_q,     retry_d;
    logic               in3_meta_q,  in3_meta_d;
    logic               in3_s_q,     in3_s_d;
    logic               in3_d_q,     in3_d_d;
    logic [3:0]         seq_q,       seq_d;
    logic [3:0]         data_q,      data_d;
    logic               oe_q,        oe_d;
    logic               started_q,   started_d;
    logic               fault_q,     fault_d;
    logic               nmi_q,       nmi_d;
    logic               rd_start;

    // Read path: two-flop synchroniser on the asynchronous strobe plus a delay
    // flop for edge detection. A falling synchronised strobe is a read start;
    // the matching read end needs no explicit detector because the bus enable
    // simply tracks the synchronised strobe one cycle later.
    always_comb begin
        in3_meta_d = port_if.IN3_AL;
        in3_s_d    = in3_meta_q;
        in3_d_d    = in3_s_q;
        rd_start   = in3_d_q & ~in3_s_q;

        seq_d     = seq_q;
        data_d    = data_q;
        oe_d      = ~in3_s_q;
        started_d = started_q | rd_start;

        if (!port_if.CLR_AL) begin
            seq_d  = 4'd0;
            data_d = 4'd0;
        end else if (rd_start) begin
            seq_d  = seq_q + 4'd1;
            data_d = seq_q + 4'd1;
        end
    end

    // NMI supervisor: delay, pulse, then either a read has been seen (RUN) or
    // the watchdog window is opened (WAIT). Watchdog expiry re-pulses until
    // the retry budget is spent, then parks in FAIL. A read during WAIT wins
    // over a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;

        case (state_q)
            ST_DELAY: begin
                if (cnt_q == DELAY_END) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == WIDTH_END) begin
                    cnt_d   = '0;
                    state_d = (started_q | rd_start) ? ST_RUN : ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (rd_start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == WDOG_END) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_PULSE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
            end
            ST_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_DELAY;
                cnt_d   = '0;
            end
        endcase

        // Registered off the next state so NMI_AL and FAULT line up exactly
        // with the cycles the FSM spends in PULSE and FAIL.
        nmi_d   = (state_d != ST_PULSE);
        fault_d = fault_q | (state_d == ST_FAIL);
    end

    // All state registers; reset is synchronous and returns every output,
    // including an NMI in mid-pulse, to its idle value on the next edge.
    always_ff @(posedge CPU_CLOCK) begin
        if (RESET) begin
            state_q    <= ST_DELAY;
            cnt_q      <= '0;
            retry_q    <= 4'd0;
            in3_meta_q <= 1'b1;
            in3_s_q    <= 1'b1;
            in3_d_q    <= 1'b1;
            seq_q      <= 4'd0;
            data_q     <= 4'd0;
            oe_q       <= 1'b0;
            started_q  <= 1'b0;
            fault_q    <= 1'b0;
            nmi_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            in3_meta_q <= in3_meta_d;
            in3_s_q    <= in3_s_d;
            in3_d_q    <= in3_d_d;
            seq_q      <= seq_d;
            data_q     <= data_d;
            oe_q       <= oe_d;
            started_q  <= started_d;
            fault_q    <= fault_d;
            nmi_q      <= nmi_d;
        end
    end

    assign port_if.NMI_AL       = nmi_q;
    assign port_if.MCU_DATA_OUT = data_q;
    assign port_if.MCU_DATA_OE  = oe_q;
    assign port_if.STARTED      = started_q;
    assign port_if.FAULT        = fault_q;

endmodule

// File: tb/tb_cpu_mcu_port_controller.sv
// ----------------------------------------------------------------------------
// tb_cpu_mcu_port_controller
//
// Purpose: directed self-checking bench for cpu_mcu_port_controller. One
// instance uses default parameters; a second uses WDOG_CYCLES=8, MAX_RETRY=0
// and only ever sees idle strobes.
//
// Cycle numbering: after reset is released, the first rising edge is cycle 0;
// cyc holds the number of the most recent edge and outputs are sampled 1 time
// unit after it.
// ----------------------------------------------------------------------------
module tb_cpu_mcu_port_controller;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = -1;

    cpu_mcu_port_controller_if bus ();
    cpu_mcu_port_controller_if bus2 ();

    // 10-unit clock period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    cpu_mcu_port_controller dut (
        .CPU_CLOCK (clk),
        .RESET     (rst),
        .port_if   (bus)
    );

    cpu_mcu_port_controller #(
        .NMI_DELAY   (16),
        .NMI_WIDTH   (4),
        .WDOG_CYCLES (8),
        .MAX_RETRY   (0)
    ) dut2 (
        .CPU_CLOCK (clk),
        .RESET     (rst),
        .port_if   (bus2)
    );

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One comparison point: counts it and reports any difference.
    task automatic check_output(input string tag, input logic [3:0] obs,
                                input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h",
                   tag, cyc, obs, exp);
        end
    endtask

    // Expected NMI_AL for the default instance when no read ever arrives.
    function automatic logic nmi_no_read(input int c);
        return !((c >= 16   && c <= 19)   || (c >= 1044 && c <= 1047) ||
                 (c >= 2072 && c <= 2075) || (c >= 3100 && c <= 3103));
    endfunction

    // Hold reset for a few edges, confirm idle outputs, then release it so
    // the next rising edge is cycle 0.
    task automatic apply_stimulus_reset();
        rst = 1'b1;
        repeat (3) tick();
        check_output("rst_nmi",     4'(bus.NMI_AL),      4'd1);
        check_output("rst_data",    bus.MCU_DATA_OUT,    4'd0);
        check_output("rst_oe",      4'(bus.MCU_DATA_OE), 4'd0);
        check_output("rst_started", 4'(bus.STARTED),     4'd0);
        check_output("rst_fault",   4'(bus.FAULT),       4'd0);
        rst = 1'b0;
        cyc = -1;
    endtask

    // One CPU read: strobe low for 5 edges, then high for 4 edges. The data
    // and enable appear on the third edge after the fall; optionally CLR_AL
    // is pulled low for exactly the edge that registers the read.
    task automatic apply_stimulus_read(input logic [3:0] exp, input bit clr);
        bus.IN3_AL = 1'b0;
        tick();
        tick();
        if (clr) bus.CLR_AL = 1'b0;
        tick();
        bus.CLR_AL = 1'b1;
        check_output("rd_data", bus.MCU_DATA_OUT,    exp);
        check_output("rd_oe",   4'(bus.MCU_DATA_OE), 4'd1);
        tick();
        tick();
        check_output("rd_hold", bus.MCU_DATA_OUT,    exp);
        bus.IN3_AL = 1'b1;
        tick();
        tick();
        check_output("rd_oe_late", 4'(bus.MCU_DATA_OE), 4'd1);
        tick();
        check_output("rd_oe_off",  4'(bus.MCU_DATA_OE), 4'd0);
        check_output("rd_after",   bus.MCU_DATA_OUT,    exp);
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        bus.IN3_AL  = 1'b1;
        bus.CLR_AL  = 1'b1;
        bus2.IN3_AL = 1'b1;
        bus2.CLR_AL = 1'b1;

        // No reads at all: four pulses, then FAULT, then silence.
        $display("[TB] watchdog retries with no reads");
        apply_stimulus_reset();
        while (cyc < 4400) begin
            tick();
            check_output("wd_nmi",   4'(bus.NMI_AL), 4'(nmi_no_read(cyc)));
            check_output("wd_fault", 4'(bus.FAULT),  4'(cyc >= 4128));
        end

        // A single read at cycle 100 stops the supervisor in RUN.
        $display("[TB] single read during the watchdog window");
        apply_stimulus_reset();
        while (cyc < 99) begin
            tick();
            check_output("run_nmi_pre", 4'(bus.NMI_AL),
                         4'(!(cyc >= 16 && cyc <= 19)));
        end
        check_output("run_oe_pre",      4'(bus.MCU_DATA_OE), 4'd0);
        check_output("run_started_pre", 4'(bus.STARTED),     4'd0);
        apply_stimulus_read(4'd1, 1'b0);
        check_output("run_started", 4'(bus.STARTED), 4'd1);
        while (cyc < 4300) begin
            tick();
            check_output("run_nmi", 4'(bus.NMI_AL), 4'd1);
        end
        check_output("run_fault", 4'(bus.FAULT), 4'd0);

        // Seventeen reads from a cleared sequence wrap through zero.
        $display("[TB] sequence wrap over 17 reads");
        apply_stimulus_reset();
        for (int i = 1; i <= 17; i++) begin
            apply_stimulus_read(4'(i % 16), 1'b0);
        end

        // CLR_AL coinciding with the fourth read start forces that read to 0.
        $display("[TB] clear overriding a read");
        apply_stimulus_reset();
        apply_stimulus_read(4'd1, 1'b0);
        apply_stimulus_read(4'd2, 1'b0);
        apply_stimulus_read(4'd3, 1'b0);
        apply_stimulus_read(4'd0, 1'b1);
        apply_stimulus_read(4'd1, 1'b0);

        // Reset in the middle of the second pulse, then a clean restart; the
        // short-watchdog instance is checked over the same restart.
        $display("[TB] reset during the second pulse");
        apply_stimulus_reset();
        while (cyc < 1045) begin
            tick();
        end
        check_output("mid_nmi_low", 4'(bus.NMI_AL), 4'd0);
        rst = 1'b1;
        tick();
        check_output("mid_rst_nmi",     4'(bus.NMI_AL),  4'd1);
        check_output("mid_rst_started", 4'(bus.STARTED), 4'd0);
        check_output("mid_rst_fault",   4'(bus.FAULT),   4'd0);
        rst = 1'b0;
        cyc = -1;
        while (cyc < 60) begin
            tick();
            check_output("restart_nmi", 4'(bus.NMI_AL),
                         4'(!(cyc >= 16 && cyc <= 19)));
            check_output("short_nmi",   4'(bus2.NMI_AL),
                         4'(!(cyc >= 16 && cyc <= 19)));
            check_output("short_fault", 4'(bus2.FAULT), 4'(cyc >= 28));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
